// File: rtl/ttt_match_ctrl.sv
// ttt_match_ctrl
// Match controller that sits in front of the tic_tac_toe datapath. It
// arbitrates the two player request ports onto the single move strobe,
// enforces turn order and a per-turn timeout, clears the board between
// games, and tallies a best-of-N match.
//
// Ports
//   clk, reset                    clock (rising edge), async active-high reset
//   start                         pulse, begins a match from IDLE or DONE
//   p1_req/p1_pos, p2_req/p2_pos  level move requests (cell 0..8)
//   current_player, winner, draw  status fed back from tic_tac_toe
//   move_valid, move_pos          one-cycle move strobe to tic_tac_toe
//   game_clear                    one-cycle board reset to tic_tac_toe
//   p1_ack/p2_ack, p1_err/p2_err  one-cycle accept / reject pulses
//   p1_score, p2_score            games won this match (saturating)
//   game_count                    games completed this match (saturating)
//   match_over, match_winner      match result, valid in DONE
//
// state  | meaning
// IDLE   | after reset, waiting for start
// CLEAR  | board reset pulse, turn timer loaded
// WAIT   | serving the on-turn player, turn timer running
// ISSUE  | move strobe and ack to the mover
// SETTLE | tic_tac_toe registers the move
// CHECK  | inspect winner / draw / occupied cell
// SCORE  | tally the finished game
// DONE   | match result held until the next start

module ttt_match_ctrl #(
    parameter int unsigned WINS_NEEDED    = 2,
    parameter int unsigned MAX_GAMES      = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_req,
    input  logic [3:0] p1_pos,
    input  logic       p2_req,
    input  logic [3:0] p2_pos,
    input  logic [1:0] current_player,
    input  logic [1:0] winner,
    input  logic       draw,
    output logic       move_valid,
    output logic [3:0] move_pos,
    output logic       game_clear,
    output logic       p1_ack,
    output logic       p2_ack,
    output logic       p1_err,
    output logic       p2_err,
    output logic [2:0] p1_score,
    output logic [2:0] p2_score,
    output logic [2:0] game_count,
    output logic       match_over,
    output logic [1:0] match_winner
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_SCORE  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [1:0] PL_1 = 2'b01;
    localparam logic [1:0] PL_2 = 2'b10;

    localparam int unsigned    TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TIMER_LOAD = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TIMER_ONE  = TW'(1);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    pos_q, pos_d;
    logic [1:0]    mover_q, mover_d;
    logic [1:0]    credit_q, credit_d;
    logic [2:0]    p1_score_q, p1_score_d;
    logic [2:0]    p2_score_q, p2_score_d;
    logic [2:0]    game_count_q, game_count_d;

    logic       on_req;
    logic [3:0] on_pos;
    logic       pos_ok;
    logic       timer_tc;
    logic       wait_err;
    logic       check_err;

    // Only the player named by current_player is ever looked at; the other
    // request simply stays pending until its turn comes round.
    always_comb begin
        on_req = 1'b0;
        on_pos = 4'd0;
        if (current_player == PL_1) begin
            on_req = p1_req;
            on_pos = p1_pos;
        end else if (current_player == PL_2) begin
            on_req = p2_req;
            on_pos = p2_pos;
        end
    end

    assign pos_ok   = (on_pos <= 4'd8);
    // Terminal count at 1: the Nth consecutive WAIT cycle is the last chance.
    assign timer_tc = (timer_q == TIMER_ONE);

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pos_d        = pos_q;
        mover_d      = mover_q;
        credit_d     = credit_q;
        p1_score_d   = p1_score_q;
        p2_score_d   = p2_score_q;
        game_count_d = game_count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_CLEAR;
                    p1_score_d   = 3'd0;
                    p2_score_d   = 3'd0;
                    game_count_d = 3'd0;
                end
            end
            S_CLEAR: begin
                state_d = S_WAIT;
                timer_d = TIMER_LOAD;
            end
            S_WAIT: begin
                // An accepted request beats a timeout landing in the same cycle.
                if (on_req && pos_ok) begin
                    state_d = S_ISSUE;
                    pos_d   = on_pos;
                    mover_d = current_player;
                end else if (timer_tc) begin
                    state_d = S_SCORE;
                    if (current_player == PL_1) begin
                        credit_d = PL_2;
                    end else if (current_player == PL_2) begin
                        credit_d = PL_1;
                    end else begin
                        credit_d = 2'b00;
                    end
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            S_ISSUE: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (winner != 2'b00) begin
                    state_d  = S_SCORE;
                    credit_d = winner;
                end else if (draw) begin
                    state_d  = S_SCORE;
                    credit_d = 2'b00;
                end else if (current_player == mover_q) begin
                    // Turn did not advance: the cell was taken. Same player
                    // retries on the remaining time.
                    state_d = S_WAIT;
                end else begin
                    state_d = S_WAIT;
                    timer_d = TIMER_LOAD;
                end
            end
            S_SCORE: begin
                if (game_count_q != 3'd7) begin
                    game_count_d = game_count_q + 3'd1;
                end
                if (credit_q[0] && (p1_score_q != 3'd7)) begin
                    p1_score_d = p1_score_q + 3'd1;
                end
                if (credit_q[1] && (p2_score_q != 3'd7)) begin
                    p2_score_d = p2_score_q + 3'd1;
                end
                if ((32'(p1_score_d) >= WINS_NEEDED) ||
                    (32'(p2_score_d) >= WINS_NEEDED) ||
                    (32'(game_count_d) >= MAX_GAMES)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            pos_q        <= 4'd0;
            mover_q      <= 2'b00;
            credit_q     <= 2'b00;
            p1_score_q   <= 3'd0;
            p2_score_q   <= 3'd0;
            game_count_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pos_q        <= pos_d;
            mover_q      <= mover_d;
            credit_q     <= credit_d;
            p1_score_q   <= p1_score_d;
            p2_score_q   <= p2_score_d;
            game_count_q <= game_count_d;
        end
    end

    assign wait_err  = (state_q == S_WAIT) && on_req && !pos_ok;
    assign check_err = (state_q == S_CHECK) && (winner == 2'b00) && !draw &&
                       (current_player == mover_q);

    assign game_clear = (state_q == S_CLEAR);
    assign move_valid = (state_q == S_ISSUE);
    assign move_pos   = move_valid ? pos_q : 4'd0;
    assign p1_ack     = move_valid && (mover_q == PL_1);
    assign p2_ack     = move_valid && (mover_q == PL_2);
    assign p1_err     = (wait_err && (current_player == PL_1)) ||
                        (check_err && (mover_q == PL_1));
    assign p2_err     = (wait_err && (current_player == PL_2)) ||
                        (check_err && (mover_q == PL_2));

    assign p1_score   = p1_score_q;
    assign p2_score   = p2_score_q;
    assign game_count = game_count_q;
    assign match_over = (state_q == S_DONE);

    always_comb begin
        match_winner = 2'b00;
        if (state_q == S_DONE) begin
            if (p1_score_q > p2_score_q) begin
                match_winner = PL_1;
            end else if (p2_score_q > p1_score_q) begin
                match_winner = PL_2;
            end else begin
                match_winner = 2'b11;
            end
        end
    end

endmodule
